uop_exh_checker: RTL and testbench
==================================

UOP_EXH_CHECKER -- requirements
Module: uop_exh_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; clk and reset are the first two ports.
REQ-002 Parameter N, default 2: DUT input width; legal range 1..8.
REQ-003 Parameter HOLD, default 1: clock cycles each vector is held before sampling; legal range 1..16.
REQ-004 Parameter MODE, default 0: expected DUT function; 0 = XNOR-reduce, 1 = XOR-reduce, 2 = AND-reduce.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 start  input  1  one-cycle request to begin a sweep.
REQ-008 stim  output  N  vector driven to the DUT inputs.
REQ-009 dut_y  input  1  DUT response.
REQ-010 busy  output  1  sweep in progress.
REQ-011 done  output  1  sweep complete; held until the next accepted start.
REQ-012 pass  output  1  valid while done; 1 = zero mismatches.
REQ-013 err_count  output  N+1  mismatch count.
REQ-014 first_fail  output  N  first failing vector; 0 if none.

Function
REQ-015 FSM states SHALL be IDLE, RUN and FINISH.
REQ-016 IDLE/FINISH + start: clear err_count, first_fail, done and pass; set stim=0, busy=1 and the hold counter to 0; go to RUN.
REQ-017 RUN: the hold counter SHALL increment each cycle; on the cycle it equals HOLD-1, the block SHALL sample dut_y, compare it with expected(stim), and reset the hold counter.
REQ-018 On mismatch, err_count SHALL increment; if err_count was 0, first_fail SHALL capture stim.
REQ-019 After a sample with stim < 2^N-1, stim SHALL increment by 1 on the same edge.
REQ-020 After the sample with stim = 2^N-1, the block SHALL go to FINISH with busy=0, done=1 and pass=(final err_count==0); stim SHALL hold its last value.
REQ-021 Latency from the start edge to done=1 SHALL be exactly 2^N*HOLD cycles.
REQ-022 start while in RUN SHALL be ignored.
REQ-023 stim SHALL wrap only by restart, never by counting past 2^N-1.
REQ-024 err_count SHALL NOT saturate; with width N+1 the maximum 2^N fits.

Reset
REQ-025 Reset SHALL take effect immediately at any time, including mid-sweep: state=IDLE, stim=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, hold counter=0.
REQ-026 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-027 Macro UOP_EXH_STOP_ON_FAIL_EN defined: the first mismatch SHALL end the sweep immediately, entering FINISH with err_count=1, pass=0 and stim holding the failing vector.
REQ-028 Macro UOP_EXH_STOP_ON_FAIL_EN undefined: the sweep SHALL always cover all 2^N vectors.

Structure
REQ-029 Package uop_exh_pkg SHALL hold the state enum, the MODE constants and function exp_y(mode, vector).
REQ-030 The vector/hold counter pair SHALL be sub-module uop_vec_counter, with ports clk, reset, clr, en, vec, last.

Verification
REQ-031 N=2, HOLD=1, MODE=0, ideal XNOR DUT, start pulse -> stim 00,01,10,11; done after 4 cycles; pass=1; err_count=0.
REQ-032 N=2, MODE=0, DUT stuck at 0 -> err_count=2 (vectors 00 and 11 fail), first_fail=00, pass=0.
REQ-033 N=3, HOLD=3, MODE=1, ideal XOR DUT -> each stim value held 3 cycles; done after 24 cycles; pass=1.
REQ-034 Reset asserted at cycle 2 of an N=2 sweep -> all outputs return to reset values at once; a new start then gives a full 4-cycle sweep.
REQ-035 start pulsed mid-sweep -> stim sequence and done timing unchanged; start in FINISH -> done=0, new sweep begins.
REQ-036 UOP_EXH_STOP_ON_FAIL_EN defined, N=2, DUT inverted (XOR, mismatches every vector) -> FINISH after 1 cycle; stim=00; err_count=1.

Source files
------------

// File: rtl/uop_exh_pkg.sv
// rtl/uop_exh_pkg.sv - shared types, MODE constants and expected-response function for the exhaustive checker
package uop_exh_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

  localparam int MODE_XNOR = 0;
  localparam int MODE_XOR  = 1;
  localparam int MODE_AND  = 2;
  localparam int MAX_N     = 8;

  // Bits of vec at or above n are ignored, so callers may zero-extend freely.
  function automatic logic exp_y(input int mode, input logic [MAX_N-1:0] vec, input int n = MAX_N);
    logic [MAX_N-1:0] w_mask;
    w_mask = (n >= MAX_N) ? '1 : MAX_N'((1 << n) - 1);
    case (mode)
      MODE_XOR: return ^(vec & w_mask);
      MODE_AND: return &(vec | ~w_mask);
      default:  return ~^(vec & w_mask);
    endcase
  endfunction

endpackage

// File: rtl/uop_vec_counter.sv
// rtl/uop_vec_counter.sv - stimulus vector counter with per-vector hold counter
module uop_vec_counter #(
  parameter int N    = 2,
  parameter int HOLD = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] vec,
  output logic         last
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

  logic [N-1:0]  r_vec;
  logic [HW-1:0] r_hold;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vec  <= '0;
      r_hold <= '0;
    end else if (clr) begin
      r_vec  <= '0;
      r_hold <= '0;
    end else if (en) begin
      if (last) begin
        r_hold <= '0;
        // Saturate at the top vector; only a clear restarts the sweep.
        if (r_vec != '1) r_vec <= r_vec + N'(1);
      end else begin
        r_hold <= r_hold + HW'(1);
      end
    end
  end

  assign vec  = r_vec;
  assign last = (r_hold == HW'(HOLD - 1));

endmodule

// File: rtl/uop_exh_checker.sv
// rtl/uop_exh_checker.sv - exhaustive sweep checker for an N-input reduce DUT; UOP_EXH_STOP_ON_FAIL_EN ends the sweep at the first mismatch
module uop_exh_checker
  import uop_exh_pkg::*;
#(
  parameter int N    = 2,
  parameter int HOLD = 1,
  parameter int MODE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  output logic [N-1:0] stim,
  input  logic         dut_y,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_count,
  output logic [N-1:0] first_fail
);

  state_t       r_state;
  logic         r_busy;
  logic         r_done;
  logic         r_pass;
  logic [N:0]   r_err;
  logic [N-1:0] r_first;

  logic [N-1:0] w_vec;
  logic         w_last;
  logic         w_clr;
  logic         w_en;
  logic         w_sample;
  logic         w_mis;
  logic         w_final;

  assign w_clr    = start && (r_state != ST_RUN);
  assign w_sample = (r_state == ST_RUN) && w_last;
  assign w_mis    = w_sample && (dut_y != exp_y(MODE, MAX_N'(w_vec), N));

`ifdef UOP_EXH_STOP_ON_FAIL_EN
  // Freeze the counter on a mismatch so stim keeps showing the failing vector.
  assign w_en    = (r_state == ST_RUN) && !w_mis;
  assign w_final = (w_sample && (w_vec == '1)) || w_mis;
`else
  assign w_en    = (r_state == ST_RUN);
  assign w_final = w_sample && (w_vec == '1);
`endif

  uop_vec_counter #(.N(N), .HOLD(HOLD)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (w_clr),
    .en    (w_en),
    .vec   (w_vec),
    .last  (w_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_err   <= '0;
      r_first <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_FINISH: begin
          if (start) begin
            r_state <= ST_RUN;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_first <= '0;
          end
        end
        ST_RUN: begin
          if (w_mis) begin
            r_err <= r_err + (N+1)'(1);
            if (r_err == '0) r_first <= w_vec;
          end
          if (w_final) begin
            r_state <= ST_FINISH;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= (r_err == '0) && !w_mis;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign stim       = w_vec;
  assign busy       = r_busy;
  assign done       = r_done;
  assign pass       = r_pass;
  assign err_count  = r_err;
  assign first_fail = r_first;

endmodule

// File: tb/tb_uop_exh_checker.sv
// tb/tb_uop_exh_checker.sv - self-checking bench for uop_exh_checker against a sweep-level reference model
module tb_uop_exh_checker;

  localparam int NA = 2, HA = 1, MA = 0;
  localparam int NB = 3, HB = 3, MB = 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_a, start_b;
  logic [7:0]    mask_a, mask_b;
  logic [NA-1:0] stim_a, ff_a;
  logic [NB-1:0] stim_b, ff_b;
  logic [NA:0]   err_a;
  logic [NB:0]   err_b;
  logic          busy_a, done_a, pass_a, dy_a;
  logic          busy_b, done_b, pass_b, dy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  function automatic logic ref_y(input int mode, input int v, input int n);
    case (mode)
      0:       return ($countones(v) % 2) == 0;
      1:       return ($countones(v) % 2) == 1;
      default: return v == ((1 << n) - 1);
    endcase
  endfunction

  // Modelled DUT: ideal response with selected vectors flipped by the mask.
  assign dy_a = ref_y(MA, int'(stim_a), NA) ^ mask_a[stim_a];
  assign dy_b = ref_y(MB, int'(stim_b), NB) ^ mask_b[stim_b];

  uop_exh_checker #(.N(NA), .HOLD(HA), .MODE(MA)) u_dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stim(stim_a), .dut_y(dy_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a)
  );

  uop_exh_checker #(.N(NB), .HOLD(HB), .MODE(MB)) u_dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stim(stim_b), .dut_y(dy_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic get_obs(input int w, output int st, output int bs, output int dn,
                         output int ps, output int er, output int ff);
    if (w == 0) begin
      st = int'(stim_a); bs = int'(busy_a); dn = int'(done_a);
      ps = int'(pass_a); er = int'(err_a);  ff = int'(ff_a);
    end else begin
      st = int'(stim_b); bs = int'(busy_b); dn = int'(done_b);
      ps = int'(pass_b); er = int'(err_b);  ff = int'(ff_b);
    end
  endtask

  task automatic set_start(input int w, input logic v);
    if (w == 0) start_a = v; else start_b = v;
  endtask

  task automatic sweep(input int w, input logic [7:0] mask, input int restart_at);
    int n, h, nv, e_err, e_ff, stop_v, e_lat, cyc;
    int st, bs, dn, ps, er, ff;
    n = (w == 0) ? NA : NB;
    h = (w == 0) ? HA : HB;
    nv = 1 << n;
    e_err = 0; e_ff = 0; stop_v = nv - 1;
    for (int v = 0; v < nv; v++) begin
      if (mask[v]) begin
        if (e_err == 0) e_ff = v;
        e_err++;
`ifdef UOP_EXH_STOP_ON_FAIL_EN
        stop_v = v;
        break;
`endif
      end
    end
    e_lat = (stop_v + 1) * h;
    if (w == 0) mask_a = mask; else mask_b = mask;

    @(negedge clk); set_start(w, 1'b1);
    @(negedge clk); set_start(w, 1'b0);
    cyc = 0;
    get_obs(w, st, bs, dn, ps, er, ff);
    while (dn == 0 && cyc < 200) begin
      chk("stim_seq", st, cyc / h);
      chk("busy_run", bs, 1);
      set_start(w, cyc == restart_at);
      @(negedge clk);
      cyc++;
      get_obs(w, st, bs, dn, ps, er, ff);
    end
    set_start(w, 1'b0);
    chk("latency", cyc, e_lat);
    chk("done", dn, 1);
    chk("busy_end", bs, 0);
    chk("pass", ps, (e_err == 0) ? 1 : 0);
    chk("err_count", er, e_err);
    chk("first_fail", ff, e_ff);
    chk("stim_final", st, stop_v);
    repeat (3) @(negedge clk);
    get_obs(w, st, bs, dn, ps, er, ff);
    chk("done_held", dn, 1);
    chk("stim_held", st, stop_v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, bs, dn, ps, er, ff;
    reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mask_a = '0; mask_b = '0;
    repeat (2) @(negedge clk);
    for (int w = 0; w < 2; w++) begin
      get_obs(w, st, bs, dn, ps, er, ff);
      chk("rst_stim", st, 0); chk("rst_busy", bs, 0); chk("rst_done", dn, 0);
      chk("rst_pass", ps, 0); chk("rst_err", er, 0);  chk("rst_ff", ff, 0);
    end
    reset = 1'b0;

    sweep(0, 8'b0000, -1);
    sweep(0, 8'b1001, -1);
    sweep(1, 8'h00, -1);
    sweep(0, 8'b1111, -1);
    sweep(0, 8'b0110, 2);
    sweep(1, 8'h90, 4);

    // Asynchronous reset mid-sweep, away from any clock edge.
    mask_a = 8'b0101;
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    get_obs(0, st, bs, dn, ps, er, ff);
    chk("midrst_stim", st, 0); chk("midrst_busy", bs, 0); chk("midrst_done", dn, 0);
    chk("midrst_pass", ps, 0); chk("midrst_err", er, 0);  chk("midrst_ff", ff, 0);
    @(negedge clk); reset = 1'b0;
    sweep(0, 8'b0000, -1);

    for (int i = 0; i < 6; i++) begin
      sweep(0, 8'($urandom_range(0, 15)), int'($urandom_range(0, 5)) - 2);
      sweep(1, 8'($urandom()), -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
